// File: rtl/wbuf_pkg.sv
// Shared types for the data-memory write buffer: FSM states, FIFO entry layout and
// the pointer-width helper used by the FIFO.
package wbuf_pkg;

    localparam int unsigned WBUF_DEPTH = 4;
    localparam int unsigned WBUF_AW    = 32;
    localparam int unsigned WBUF_DW    = 32;

    typedef enum logic [1:0] {IDLE, DRAIN, LOAD, RESP} state_e;

    // Entries keep only the word address; byte offsets are never compared.
    typedef struct packed {
        logic [WBUF_AW-3:0] word_addr;
        logic [WBUF_DW-1:0] data;
    } wbuf_entry_t;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int unsigned WBUF_PTR_W = ptr_w(WBUF_DEPTH);

endpackage

// File: rtl/wbuf_fifo.sv
// Circular store FIFO; exposes every slot age-ordered from the head (index 0 = oldest)
// together with a valid vector so the parent can search for forwarding hits.
module wbuf_fifo
    import wbuf_pkg::*;
#(
    parameter int unsigned DEPTH = WBUF_DEPTH
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             i_push,
    input  wbuf_entry_t      i_entry,
    input  logic             i_pop,
    output logic             o_full,
    output wbuf_entry_t      o_entries [DEPTH],
    output logic [DEPTH-1:0] o_valid
);

    localparam int unsigned    PTR_W    = ptr_w(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] ONE_CNT  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] ONE_PTR = PTR_W'(1);

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;
    wbuf_entry_t      r_mem [DEPTH];
    logic             w_push;
    logic             w_pop;

    assign o_full = (r_count == FULL_CNT);
    // A full FIFO refuses the push even when the head pops on the same edge.
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && (r_count != '0);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + ONE_PTR;
            end
            if (w_pop) begin
                r_head <= r_head + ONE_PTR;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + ONE_CNT;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - ONE_CNT;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_tail] <= i_entry;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            o_entries[i] = r_mem[r_head + PTR_W'(i)];
            o_valid[i]   = ((PTR_W+1)'(i) < r_count);
        end
    end

endmodule

// File: rtl/dmem_write_buffer.sv
// Write buffer between the M stage and a slow req/ack data memory. Define LOAD_FORWARD_EN
// to forward loads from queued stores; otherwise loads wait for the buffer to empty.
module dmem_write_buffer
    import wbuf_pkg::*;
#(
    parameter int unsigned DEPTH = WBUF_DEPTH,
    parameter int unsigned AW    = WBUF_AW,
    parameter int unsigned DW    = WBUF_DW
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic [AW-1:0] addr_m_i,
    input  logic [DW-1:0] wdata_m_i,
    input  logic          memwrite_m_i,
    input  logic          memread_m_i,
    output logic [DW-1:0] readdata_m_o,
    output logic          stall_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic          mem_ack_i,
    input  logic [DW-1:0] mem_rdata_i
);

    state_e           r_state;
    state_e           w_state_d;
    logic             r_req;
    logic             w_req_d;
    logic             r_we;
    logic             w_we_d;
    logic [AW-1:0]    r_addr;
    logic [AW-1:0]    w_addr_d;
    logic [DW-1:0]    r_wdata;
    logic [DW-1:0]    w_wdata_d;
    logic [DW-1:0]    r_rdata;
    logic [DW-1:0]    w_rdata_d;

    wbuf_entry_t      w_push_entry;
    wbuf_entry_t      w_entries [DEPTH];
    logic [DEPTH-1:0] w_valid;
    logic             w_full;
    logic             w_pop;
    logic             w_load;
    logic             w_load_miss;
    logic             w_fwd_hit;
    logic [DW-1:0]    w_fwd_data;
    logic [AW-3:0]    w_word_addr;

    assign w_word_addr  = addr_m_i[AW-1:2];
    assign w_push_entry = '{word_addr: w_word_addr, data: wdata_m_i};
    // A store and a load together cannot happen; if they do, the store wins.
    assign w_load       = memread_m_i && !memwrite_m_i;
    assign w_pop        = (r_state == DRAIN) && mem_ack_i;

    wbuf_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .i_push   (memwrite_m_i),
        .i_entry  (w_push_entry),
        .i_pop    (w_pop),
        .o_full   (w_full),
        .o_entries(w_entries),
        .o_valid  (w_valid)
    );

`ifdef LOAD_FORWARD_EN
    // Head is the in-flight drain entry, so it is searched too; later slots are younger.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (w_valid[i] && (w_entries[i].word_addr == w_word_addr)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = w_entries[i].data;
            end
        end
    end
    assign w_load_miss = w_load && !w_fwd_hit && (r_state != RESP);
`else
    assign w_fwd_hit   = 1'b0;
    assign w_fwd_data  = '0;
    assign w_load_miss = w_load && !w_valid[0] && (r_state != DRAIN) && (r_state != RESP);
`endif

    always_comb begin
        w_state_d = r_state;
        w_req_d   = r_req;
        w_we_d    = r_we;
        w_addr_d  = r_addr;
        w_wdata_d = r_wdata;
        w_rdata_d = r_rdata;
        case (r_state)
            // The load seen in RESP is the one being answered, so it is masked out.
            IDLE, RESP: begin
                if (w_load_miss) begin
                    w_state_d = LOAD;
                    w_req_d   = 1'b1;
                    w_we_d    = 1'b0;
                    w_addr_d  = {w_word_addr, 2'b00};
                end else if (w_valid[0]) begin
                    w_state_d = DRAIN;
                    w_req_d   = 1'b1;
                    w_we_d    = 1'b1;
                    w_addr_d  = {w_entries[0].word_addr, 2'b00};
                    w_wdata_d = w_entries[0].data;
                end else begin
                    w_state_d = IDLE;
                    w_req_d   = 1'b0;
                end
            end
            DRAIN: begin
                if (mem_ack_i) begin
                    if (w_load_miss) begin
                        w_state_d = LOAD;
                        w_req_d   = 1'b1;
                        w_we_d    = 1'b0;
                        w_addr_d  = {w_word_addr, 2'b00};
                    end else if (w_valid[1]) begin
                        w_addr_d  = {w_entries[1].word_addr, 2'b00};
                        w_wdata_d = w_entries[1].data;
                    end else if (memwrite_m_i) begin
                        // Last entry pops while a new store lands: it becomes the next head.
                        w_addr_d  = {w_word_addr, 2'b00};
                        w_wdata_d = wdata_m_i;
                    end else begin
                        w_state_d = IDLE;
                        w_req_d   = 1'b0;
                    end
                end
            end
            LOAD: begin
                if (mem_ack_i) begin
                    w_state_d = RESP;
                    w_req_d   = 1'b0;
                    w_rdata_d = mem_rdata_i;
                end
            end
            default: begin
                w_state_d = IDLE;
                w_req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_d;
            r_req   <= w_req_d;
            r_we    <= w_we_d;
            r_addr  <= w_addr_d;
            r_wdata <= w_wdata_d;
            r_rdata <= w_rdata_d;
        end
    end

    assign mem_req_o   = r_req;
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;

    assign stall_o = !reset_i && ((memwrite_m_i && w_full) ||
                                  (w_load && !w_fwd_hit && (r_state != RESP)));

    always_comb begin
        readdata_m_o = '0;
        if (w_load && w_fwd_hit) begin
            readdata_m_o = w_fwd_data;
        end else if (r_state == RESP) begin
            readdata_m_o = r_rdata;
        end
    end

endmodule
